// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI mode-0 slave.
package spi_pkg;

    localparam int         SPI_DATA_WIDTH  = 8;
    localparam int         SPI_SYNC_STAGES = 2;
    localparam logic [7:0] SPI_IDLE_FILL   = 8'h00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Bus-side signals of the SPI slave: serial pins plus TX/RX buffer handshakes.
interface spi_slave_if #(
    parameter int DATA_WIDTH = spi_pkg::SPI_DATA_WIDTH
) ();

    logic                  spi_clk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ack;
    logic                  rx_overrun;
    logic                  busy;

    modport slave (
        input  spi_clk, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ack,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
    );

    modport master (
        output spi_clk, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ack,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with one history flop
// providing single-cycle rise/fall pulses aligned to the synchronized level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES  = SPI_SYNC_STAGES,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              hist;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync <= {STAGES{RST_VAL}};
            hist <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            hist <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~hist;
    assign fall = ~q & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples the serial link on clk, deserializes MOSI MSB
// first, and serves MISO from a one-entry TX buffer (IDLE_FILL when empty).
module spi_slave
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int                    SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = DATA_WIDTH'(SPI_IDLE_FILL)
) (
    input logic        clk,
    input logic        resetn,
    spi_slave_if.slave bus
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Synchronized serial inputs
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.spi_clk),
        .q      (sclk_lvl_unused),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    // cs_n resets to its idle-high level so reset release never fakes a select
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.spi_cs_n),
        .q      (cs_q),
        .rise   (cs_rise),
        .fall   (cs_fall)
    );

    // Same depth as the sclk path, so mosi_q is the level seen at the sclk edge
    always_ff @(posedge clk) begin
        if (!resetn) mosi_sync <= '0;
        else         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
    end
    assign mosi_q = mosi_sync[SYNC_STAGES-1];

    // State
    state_e                state, state_d;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data, rx_data_d;
    logic                  rx_valid, rx_valid_d;
    logic                  rx_overrun, rx_overrun_d;
    logic [DATA_WIDTH-1:0] tx_buf, tx_buf_d;
    logic                  tx_full, tx_full_d;
    logic                  miso_oe, miso_oe_d;
    logic                  load;
    logic [DATA_WIDTH-1:0] rx_next;

    assign rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_q};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            tx_buf     <= '0;
            tx_full    <= 1'b0;
            miso_oe    <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            tx_shift   <= tx_shift_d;
            rx_shift   <= rx_shift_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            rx_overrun <= rx_overrun_d;
            tx_buf     <= tx_buf_d;
            tx_full    <= tx_full_d;
            miso_oe    <= miso_oe_d;
        end
    end

    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        tx_shift_d   = tx_shift;
        rx_shift_d   = rx_shift;
        rx_data_d    = rx_data;
        rx_valid_d   = rx_valid;
        rx_overrun_d = rx_overrun;
        tx_buf_d     = tx_buf;
        tx_full_d    = tx_full;
        miso_oe_d    = miso_oe;
        load         = 1'b0;

        if (bus.tx_valid && !tx_full) begin
            tx_buf_d  = bus.tx_data;
            tx_full_d = 1'b1;
        end
        if (bus.rx_ack) rx_valid_d = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    miso_oe_d = 1'b1;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_oe_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt == LAST_BIT) begin
                        // A same-cycle ack frees the slot, so no overrun then
                        rx_data_d    = rx_next;
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_overrun | (rx_valid & ~bus.rx_ack);
                        bit_cnt_d    = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt != '0) tx_shift_d = tx_shift << 1;
                    else               load       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Load only consumes a full buffer, which cannot be filled this cycle
        if (load) begin
            if (tx_full) begin
                tx_shift_d = tx_buf;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = IDLE_FILL;
            end
        end
    end

    assign bus.spi_miso    = miso_oe & tx_shift[DATA_WIDTH-1];
    assign bus.spi_miso_oe = miso_oe;
    assign bus.tx_ready    = ~tx_full;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.rx_overrun  = rx_overrun;
    assign bus.busy        = ~cs_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master at clk/8 with a byte-level model
// of the TX buffer, MISO stream and RX register/overrun flags.
module tb_spi_slave;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_WIDTH(8)) bus ();

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_FILL(8'h00)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: TX buffer, byte the slave will shift out next, RX register
    logic [7:0] m_buf  = 8'h00;
    bit         m_full = 1'b0;
    logic [7:0] m_miso = 8'h00;
    logic [7:0] m_rxd  = 8'h00;
    bit         m_rxv  = 1'b0;
    bit         m_ovr  = 1'b0;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Slave loads its shifter at CS fall and at every frame-end sclk fall
    task automatic model_take();
        m_miso = m_full ? m_buf : 8'h00;
        m_full = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] v);
        check1("tx_ready_pre_push", bus.tx_ready, 1'b1);
        bus.tx_data  = v;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        m_buf  = v;
        m_full = 1'b1;
    endtask

    task automatic do_ack();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        m_rxv = 1'b0;
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        model_take();
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        bus.spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Mode 0: MOSI set while sclk low, MISO sampled at the rising edge
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit push_en,
                            input logic [7:0] pv, input bit ack_last, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = mo[7-i];
            if (push_en && i == 4) push_tx(pv);
            else                   @(negedge clk);
            repeat (3) @(negedge clk);
            bus.spi_clk = 1'b1;
            mi[7-i] = bus.spi_miso;
            if (ack_last && i == nbits - 1) begin
                repeat (2) @(negedge clk);
                bus.rx_ack = 1'b1;
                @(negedge clk);
                bus.rx_ack = 1'b0;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            bus.spi_clk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] mo, input bit push_en,
                            input logic [7:0] pv, input bit ack_last);
        logic [7:0] mi;
        logic [7:0] exp_mi;
        exp_mi = m_miso;
        spi_bits(mo, 8, push_en, pv, ack_last, mi);
        if (!ack_last) m_ovr = m_ovr | m_rxv;
        m_rxv = 1'b1;
        m_rxd = mo;
        check8({tag, "_miso"},  mi,             exp_mi);
        check8({tag, "_rxd"},   bus.rx_data,    m_rxd);
        check1({tag, "_rxv"},   bus.rx_valid,   m_rxv);
        check1({tag, "_ovr"},   bus.rx_overrun, m_ovr);
        model_take();
    endtask

    initial begin
        logic [7:0] junk;
        bit active;
        bus.spi_clk  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.rx_ack   = 1'b0;
        resetn       = 1'b0;
        repeat (3) @(negedge clk);

        check1("rst_tx_ready", bus.tx_ready,    1'b1);
        check1("rst_rx_valid", bus.rx_valid,    1'b0);
        check8("rst_rx_data",  bus.rx_data,     8'h00);
        check1("rst_overrun",  bus.rx_overrun,  1'b0);
        check1("rst_miso_oe",  bus.spi_miso_oe, 1'b0);
        check1("rst_miso",     bus.spi_miso,    1'b0);
        check1("rst_busy",     bus.busy,        1'b0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame with preloaded A5
        push_tx(8'hA5);
        check1("full_tx_ready", bus.tx_ready, 1'b0);
        cs_low();
        check1("sel_tx_ready", bus.tx_ready,    1'b1);
        check1("sel_busy",     bus.busy,        1'b1);
        check1("sel_miso_oe",  bus.spi_miso_oe, 1'b1);
        do_frame("single", 8'h3C, 1'b0, 8'h00, 1'b0);
        cs_high();
        check1("desel_miso_oe", bus.spi_miso_oe, 1'b0);
        check1("desel_miso",    bus.spi_miso,    1'b0);
        check1("desel_busy",    bus.busy,        1'b0);
        do_ack();
        check1("ack_rx_valid", bus.rx_valid, m_rxv);

        // Empty TX buffer, then ack colliding with completion
        cs_low();
        do_frame("empty", 8'hFF, 1'b0, 8'h00, 1'b0);
        do_frame("ackcol", 8'h77, 1'b0, 8'h00, 1'b1);
        cs_high();
        do_ack();

        // Abort after 5 bits, then a clean frame
        cs_low();
        spi_bits(8'hC3, 5, 1'b0, 8'h00, 1'b0, junk);
        bus.spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check1("abort_miso_oe", bus.spi_miso_oe, 1'b0);
        check1("abort_miso",    bus.spi_miso,    1'b0);
        @(negedge clk);
        check1("abort_rx_valid", bus.rx_valid, 1'b0);
        cs_low();
        do_frame("post_abort", 8'h81, 1'b0, 8'h00, 1'b0);
        cs_high();
        do_ack();

        // Back-to-back with mid-frame refill; second byte unread -> overrun
        push_tx(8'hA5);
        cs_low();
        do_frame("b2b1", 8'h11, 1'b1, 8'h5A, 1'b0);
        do_frame("b2b2", 8'h22, 1'b0, 8'h00, 1'b0);
        cs_high();

        // Randomized traffic
        active = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!m_full && $urandom_range(0, 2) == 0) push_tx(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) do_ack();
            if (!active) begin
                cs_low();
                active = 1'b1;
            end
            do_frame("rnd", 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                cs_high();
                active = 1'b0;
            end
        end
        if (active) cs_high();

        // Reset mid-frame with a full TX buffer
        if (!m_full) push_tx(8'h99);
        cs_low();
        spi_bits(8'hE7, 3, 1'b0, 8'h00, 1'b0, junk);
        resetn = 1'b0;
        @(negedge clk);
        m_full = 1'b0; m_rxv = 1'b0; m_ovr = 1'b0; m_rxd = 8'h00;
        check1("mrst_tx_ready", bus.tx_ready,    1'b1);
        check1("mrst_rx_valid", bus.rx_valid,    1'b0);
        check1("mrst_miso_oe",  bus.spi_miso_oe, 1'b0);
        check1("mrst_busy",     bus.busy,        1'b0);
        check1("mrst_overrun",  bus.rx_overrun,  1'b0);
        check8("mrst_rx_data",  bus.rx_data,     8'h00);
        resetn = 1'b1;
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        cs_low();
        do_frame("post_rst", 8'h5C, 1'b0, 8'h00, 1'b0);
        cs_high();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI mode-0 responder, the far end of the SoC SPI master's spi_clk/spi_mosi/spi_miso link. It oversamples the external serial clock and chip select on the 16 MHz system clock and deserializes MOSI into bytes. MISO is served from a one-entry transmit buffer. Used as a loopback/peer target in SoC benches and as an FPGA-side slave port.

Parameters:
DATA_WIDTH, 8, bits per SPI frame
SYNC_STAGES, 2, synchronizer flops on spi_clk/spi_cs_n/spi_mosi (min 2)
IDLE_FILL, 8'h00, byte shifted out when the TX buffer is empty

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
spi_clk  in  1  serial clock from master, asynchronous to clk, idles low
spi_cs_n  in  1  chip select, active low, asynchronous
spi_mosi  in  1  master-out data
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  MISO output enable, high only while selected
tx_data  in  DATA_WIDTH  byte to send on the next frame
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX buffer empty; transfer when tx_valid & tx_ready
rx_data  out  DATA_WIDTH  last complete received byte
rx_valid  out  1  rx_data holds an unread byte (level)
rx_ack  in  1  consumer has read rx_data; clears rx_valid
rx_overrun  out  1  sticky: a byte completed while rx_valid=1
busy  out  1  high while synchronized cs_n is low

Behaviour:
- Reset (resetn=0 at posedge clk): all outputs 0 except tx_ready=1; rx_data=0, bit_cnt=0, state IDLE, TX buffer empty.
- Sync: spi_clk, spi_cs_n, spi_mosi each pass through SYNC_STAGES flops, plus one history flop for edge detect. An external edge is seen as an internal event SYNC_STAGES+1 clk later (3 at default). Supported spi_clk <= clk/8.
- FSM IDLE -> ACTIVE on synced cs_n falling edge:
  - load tx_shift from the TX buffer if full (buffer empties, tx_ready rises next cycle), else IDLE_FILL;
  - bit_cnt=0; spi_miso_oe=1; spi_miso=tx_shift MSB.
- ACTIVE, sclk rising edge: rx_shift <= {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
- When bit_cnt reaches W-1 on a rising edge (the frame's final bit):
  - rx_data <= the completed byte; rx_valid <= 1;
  - rx_overrun <= 1 if rx_valid was already 1 and rx_ack is not asserted this cycle;
  - bit_cnt wraps to 0.
- ACTIVE, sclk falling edge with bit_cnt!=0: tx_shift shifts left; spi_miso = new MSB.
- ACTIVE, sclk falling edge with bit_cnt==0 (frame boundary, continuous CS): reload tx_shift from the buffer or IDLE_FILL, same as at CS fall.
- Bit order is MSB first for both directions.
- ACTIVE -> IDLE on synced cs_n rising edge at any bit_cnt:
  - a partial frame is discarded with no rx_valid;
  - bit_cnt=0; spi_miso_oe=0; spi_miso=0.
- Buffer handshakes:
  - TX: a transfer when tx_valid&tx_ready fills the buffer. A fill and a shift-load in the same cycle cannot collide because load requires buffer full, i.e. tx_ready=0.
  - RX: rx_ack with rx_valid=0 is ignored. rx_ack in the same cycle as a byte completion: new byte written, rx_valid stays 1, no overrun.
  - rx_overrun clears only on reset.
- sclk edges while cs_n is high are ignored.
- resetn low mid-frame: immediate return to reset values; the master's frame is lost.

Decomposition:
- Package spi_pkg: DATA_WIDTH default, IDLE_FILL constant, state enum {IDLE, ACTIVE}.
- One sub-module, spi_sync_edge: an N-stage synchronizer with rise/fall pulse outputs, instantiated for spi_clk and spi_cs_n. spi_mosi uses its level output only.

Test Plan:
- Single frame: preload tx_data=8'hA5, CS low, master sends 8'h3C at sclk=clk/8 -> rx_data=8'h3C with rx_valid=1 after the 8th rise (+3 clk); MISO bits sampled by the master = 1010_0101; tx_ready=1 after CS fall.
- Back-to-back: CS held low, master sends 8'h11 then 8'h22; tx buffer refilled with 8'h5A between frames -> two rx_valid events; master receives A5 then 5A; after the second byte without rx_ack, rx_overrun=1.
- Empty TX: no tx_valid, master sends 8'hFF -> MISO returns 8'h00; rx_data=8'hFF.
- Abort: CS rises after 5 sclk edges -> rx_valid stays 0, spi_miso_oe=0 within 3 clk. A following full frame of 8'h81 is received correctly with bit_cnt restarted.
- Ack collision: rx_valid=1, rx_ack asserted in the same cycle a new byte 8'h77 completes -> rx_data=8'h77, rx_valid=1, rx_overrun=0.
- Reset: resetn=0 for 1 clk mid-frame -> next cycle tx_ready=1, rx_valid=0, spi_miso_oe=0, busy=0.
